// File: rtl/sevenseg_scan_if.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_if
//   Load-side bus of the multiplexed seven-segment scanner. The producer
//   (master) presents a binary value and a decimal-point mask and pulses load.
//   The scanner (slave) answers with busy while it converts the value to BCD.
//
//   Signals:
//     value   [VAL_W]  unsigned binary number to display
//     load    [1]      single-cycle convert/display request
//     dp_mask [DIGITS] per-digit decimal point request, captured with value
//     busy    [1]      conversion in progress
// ---------------------------------------------------------------------------
interface sevenseg_scan_if #(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 14
);
  logic [VAL_W-1:0]  value;
  logic              load;
  logic [DIGITS-1:0] dp_mask;
  logic              busy;

  modport master (output value, output load, output dp_mask, input busy);
  modport slave  (input value, input load, input dp_mask, output busy);
endinterface

// File: rtl/sevenseg_scan.sv
// ---------------------------------------------------------------------------
// sevenseg_scan
//   Converts a binary value to decimal with a sequential double-dabble
//   (one input bit per clock) and drives a time-multiplexed, active-low
//   seven-segment display. Digit slots advance on a clock-enable tick from a
//   free-running refresh counter; no derived clocks are used.
//
//   Parameters:
//     DIGITS      number of digits (1..8)
//     VAL_W       width of the binary input (1..27)
//     REFRESH_DIV clk cycles per digit slot (2..2^20)
//
//   Ports:
//     clk   in   single clock, rising edge
//     rst   in   asynchronous active-high reset
//     bus   slave modport of sevenseg_scan_if (value, load, dp_mask, busy)
//     an    out  digit enables, active-low, one-hot-low while scanning
//     seg   out  segments a..g on seg[6]..seg[0], active-low
//     dp    out  decimal point, active-low
//
//   Optional feature: define SEVENSEG_BLANK_EN to blank leading zero digits
//   above the most significant nonzero digit (digit 0 is never blanked).
// ---------------------------------------------------------------------------
module sevenseg_scan #(
  parameter int DIGITS      = 4,
  parameter int VAL_W       = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  sevenseg_scan_if.slave    bus,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BIT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int BCD_W = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(VAL_W - 1);
  localparam logic [31:0]      MAX_SHOWN = 32'(10 ** DIGITS - 1);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  // Active-low segment pattern for one BCD digit.
  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    case (d)
      4'd0:    decode_digit = 7'b0000001;
      4'd1:    decode_digit = 7'b1001111;
      4'd2:    decode_digit = 7'b0010010;
      4'd3:    decode_digit = 7'b0000110;
      4'd4:    decode_digit = 7'b1001100;
      4'd5:    decode_digit = 7'b0100100;
      4'd6:    decode_digit = 7'b0100000;
      4'd7:    decode_digit = 7'b0001111;
      4'd8:    decode_digit = 7'b0000000;
      4'd9:    decode_digit = 7'b0000100;
      default: decode_digit = 7'b1111111;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  refresh_q, refresh_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              scan_on_q, scan_on_d;
  logic [VAL_W-1:0]  shift_q, shift_d;
  logic [BCD_W-1:0]  work_q, work_d;
  logic [BIT_W-1:0]  bits_q, bits_d;
  logic [DIGITS-1:0] cap_dp_q, cap_dp_d;
  logic              cap_ovf_q, cap_ovf_d;
  logic [BCD_W-1:0]  disp_bcd_q, disp_bcd_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic              disp_ovf_q, disp_ovf_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              tick;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  next_work;
  logic [DIGITS-1:0] blank_vec;
  logic [3:0]        cur_digit;
  logic              cur_dp;
  logic              cur_blank;
`ifdef SEVENSEG_BLANK_EN
  logic              lead_zero;
`endif

  always_comb begin
    state_d    = state_q;
    refresh_d  = refresh_q;
    idx_d      = idx_q;
    scan_on_d  = scan_on_q;
    shift_d    = shift_q;
    work_d     = work_q;
    bits_d     = bits_q;
    cap_dp_d   = cap_dp_q;
    cap_ovf_d  = cap_ovf_q;
    disp_bcd_d = disp_bcd_q;
    disp_dp_d  = disp_dp_q;
    disp_ovf_d = disp_ovf_q;
    an_d       = an_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    adj        = work_q;
    next_work  = work_q;
    blank_vec  = '0;
    cur_digit  = 4'd0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
`ifdef SEVENSEG_BLANK_EN
    lead_zero  = 1'b1;
`endif

    tick      = (refresh_q == CNT_LAST);
    refresh_d = tick ? '0 : refresh_q + CNT_W'(1);

    // Double-dabble: add 3 to every digit >= 5, then shift in the next
    // input bit. Only the lower DIGITS digits are kept; anything that would
    // land above them is an overflow case and is flagged at capture time.
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    next_work = BCD_W'({adj, shift_q[VAL_W-1]});

    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          shift_d   = bus.value;
          work_d    = '0;
          bits_d    = BIT_LAST;
          cap_dp_d  = bus.dp_mask;
          cap_ovf_d = (32'(bus.value) > MAX_SHOWN);
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        work_d  = next_work;
        shift_d = shift_q << 1;
        if (bits_q == '0) begin
          // Last bit: publish result, mask and overflow in one edge.
          disp_bcd_d = next_work;
          disp_dp_d  = cap_dp_q;
          disp_ovf_d = cap_ovf_q;
          state_d    = S_IDLE;
        end else begin
          bits_d = bits_q - BIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SEVENSEG_BLANK_EN
    // A digit is blank while it and every digit above it is zero.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead_zero    = lead_zero && (disp_bcd_q[4*i +: 4] == 4'd0);
      blank_vec[i] = lead_zero;
    end
`endif

    // The first tick after reset lights digit 0 without advancing; later
    // ticks step the index and reload the output registers together.
    if (tick) begin
      scan_on_d = 1'b1;
      if (scan_on_q && (idx_q != IDX_LAST)) idx_d = idx_q + IDX_W'(1);
      else                                  idx_d = '0;
      for (int i = 0; i < DIGITS; i++) begin
        if (IDX_W'(i) == idx_d) begin
          cur_digit = disp_bcd_q[4*i +: 4];
          cur_dp    = disp_dp_q[i];
          cur_blank = blank_vec[i];
        end
      end
      an_d = ~(DIGITS'(1) << idx_d);
      if (disp_ovf_q)     seg_d = 7'b1111110;
      else if (cur_blank) seg_d = 7'b1111111;
      else                seg_d = decode_digit(cur_digit);
      dp_d = ~cur_dp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      refresh_q  <= '0;
      idx_q      <= '0;
      scan_on_q  <= 1'b0;
      shift_q    <= '0;
      work_q     <= '0;
      bits_q     <= '0;
      cap_dp_q   <= '0;
      cap_ovf_q  <= 1'b0;
      disp_bcd_q <= '0;
      disp_dp_q  <= '0;
      disp_ovf_q <= 1'b0;
      an_q       <= '1;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      scan_on_q  <= scan_on_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      bits_q     <= bits_d;
      cap_dp_q   <= cap_dp_d;
      cap_ovf_q  <= cap_ovf_d;
      disp_bcd_q <= disp_bcd_d;
      disp_dp_q  <= disp_dp_d;
      disp_ovf_q <= disp_ovf_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.busy = (state_q == S_CONV);
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_scan
//   Random and directed loads against a reference that works in decimal
//   arithmetic: the shown digit is (value / 10^pos) % 10, the active slot
//   follows from the cycle number since reset, and a load completes a fixed
//   VAL_W cycles after it is accepted.
// ---------------------------------------------------------------------------
module tb_sevenseg_scan;

  localparam int DIGITS      = 4;
  localparam int VAL_W       = 14;
  localparam int REFRESH_DIV = 4;

  logic              clk;
  logic              rst;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  logic              dp;

  sevenseg_scan_if #(.DIGITS(DIGITS), .VAL_W(VAL_W)) bus ();

  sevenseg_scan #(
    .DIGITS(DIGITS), .VAL_W(VAL_W), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .an(an), .seg(seg), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  int                cyc;
  bit                mBusy;
  int                doneAt;
  int                pendVal;
  logic [DIGITS-1:0] pendDp;
  int                shownVal;
  logic [DIGITS-1:0] shownDp;
  logic [DIGITS-1:0] expAn;
  logic [6:0]        expSeg;
  logic              expDp;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [6:0] digitSeg(input int val, input int pos);
    if (val >= pow10(DIGITS)) return 7'b1111110;
`ifdef SEVENSEG_BLANK_EN
    if (pos > 0 && val < pow10(pos)) return 7'b1111111;
`endif
    return segOf((val / pow10(pos)) % 10);
  endfunction

  task automatic resetModel();
    cyc      = 0;
    mBusy    = 0;
    doneAt   = 0;
    pendVal  = 0;
    pendDp   = '0;
    shownVal = 0;
    shownDp  = '0;
    expAn    = '1;
    expSeg   = 7'b1111111;
    expDp    = 1'b1;
  endtask

  // One clock: advance the reference at the rising edge, compare at the
  // falling edge. Inputs must already be set (at a falling edge).
  task automatic stepCycle();
    bit busyBefore;
    int slot;
    @(posedge clk);
    cyc++;
    busyBefore = mBusy;
    if (cyc % REFRESH_DIV == 0) begin
      slot   = (cyc / REFRESH_DIV - 1) % DIGITS;
      expAn  = ~(DIGITS'(1) << slot);
      expSeg = digitSeg(shownVal, slot);
      expDp  = ~shownDp[slot];
    end
    if (busyBefore && cyc == doneAt) begin
      shownVal = pendVal;
      shownDp  = pendDp;
      mBusy    = 0;
    end else if (!busyBefore && bus.load) begin
      pendVal = int'(bus.value);
      pendDp  = bus.dp_mask;
      doneAt  = cyc + VAL_W;
      mBusy   = 1;
    end
    @(negedge clk);
    checkOutput("an", 32'(an), 32'(expAn));
    checkOutput("seg", 32'(seg), 32'(expSeg));
    checkOutput("dp", 32'(dp), 32'(expDp));
    checkOutput("busy", 32'(bus.busy), 32'(mBusy));
  endtask

  task automatic idle(input int n);
    bus.load = 1'b0;
    for (int k = 0; k < n; k++) stepCycle();
  endtask

  // Present value/mask with load held for holdCycles cycles.
  task automatic applyStimulus(input int val, input logic [DIGITS-1:0] mask, input int holdCycles);
    bus.value   = VAL_W'(val);
    bus.dp_mask = mask;
    bus.load    = 1'b1;
    for (int k = 0; k < holdCycles; k++) stepCycle();
    bus.load = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_an"}, 32'(an), 32'hF);
    checkOutput({tag, "_seg"}, 32'(seg), 32'h7F);
    checkOutput({tag, "_dp"}, 32'(dp), 32'h1);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    int val;
    int mode;
    rst         = 1'b1;
    bus.load    = 1'b0;
    bus.value   = '0;
    bus.dp_mask = '0;
    resetModel();
    repeat (3) @(negedge clk);
    checkResetOutputs("rst");
    rst = 1'b0;

    $display("[TB] free-running scan after reset");
    idle(24);

    $display("[TB] directed loads");
    applyStimulus(1234, 4'b0000, 1);
    idle(40);
    applyStimulus(10000, 4'b0100, 1);
    idle(40);
    applyStimulus(42, 4'b0001, 1);
    applyStimulus(99, 4'b1000, 1);
    idle(40);
    applyStimulus(7, 4'b0010, 1);
    idle(36);
    applyStimulus(9999, 4'b1111, 1);
    idle(36);
    applyStimulus(0, 4'b0000, 1);
    idle(36);
    applyStimulus(16383, 4'b0000, 1);
    idle(36);
    applyStimulus(305, 4'b0011, 20);
    idle(36);

    $display("[TB] randomized loads");
    for (int n = 0; n < 60; n++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0:       val = int'($urandom_range(0, 9999));
        1:       val = int'($urandom_range(0, 99));
        2:       val = int'($urandom_range(9990, 16383));
        default: val = int'($urandom_range(0, 16383));
      endcase
      applyStimulus(val, DIGITS'($urandom_range(0, 15)), int'($urandom_range(1, 18)));
      if ($urandom_range(0, 3) == 0) applyStimulus(int'($urandom_range(0, 16383)), 4'b1001, 1);
      idle(int'($urandom_range(0, 40)));
    end
    idle(40);

    $display("[TB] reset during conversion");
    applyStimulus(1234, 4'b0000, 1);
    idle(5);
    #2 rst = 1'b1;
    #1 checkResetOutputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("held_rst");
    rst = 1'b0;
    resetModel();
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
